mining_host: RTL and testbench
==============================

// Module: mining_host
// PURPOSE
//  Host-side counterpart of the UART mining core. Holds a 128-byte block-header job and streams it
//  byte-serially to a UART transmitter. Then collects the 32-byte hash/nonce result that the miner
//  returns through a UART receiver and presents it as one 256-bit word with a done pulse.
//  A timeout watchdog guards the whole response phase.
// PARAMETERS
//  n          8         UART byte width
//  HDR_BYTES  128       job bytes sent per start (address width = $clog2(HDR_BYTES))
//  RES_BYTES  32        result bytes expected back (result width = n*RES_BYTES)
//  TIMEOUT    16777216  max idle cycles between start of WAIT / any rx byte and next rx byte
// PORTS
//  clk_i       in   1      system clock, all logic on rising edge
//  rst_i       in   1      asynchronous, active-low reset
//  ld_en_i     in   1      write one header byte into job buffer (ignored while busy_o=1)
//  ld_addr_i   in   7      header byte index 0..127
//  ld_data_i   in   n      header byte value
//  start_i     in   1      launch job (sampled only in IDLE)
//  busy_o      out  1      1 in any state other than IDLE
//  tx_data_o   out  n      byte to UART transmitter
//  tx_valid_o  out  1      tx_data_o valid
//  tx_ready_i  in   1      transmitter accepts byte when tx_valid_o&tx_ready_i
//  rx_data_i   in   n      byte from UART receiver
//  rx_valid_i  in   1      one-cycle strobe, rx_data_i valid
//  hash_o      out  256    assembled result, byte k at [8k+7:8k]
//  done_o      out  1      one-cycle pulse, hash_o newly complete
//  timeout_o   out  1      one-cycle pulse, response phase aborted
// BEHAVIOUR
//  Reset (rst_i=0, async):
//   - state=IDLE; all outputs 0; counters 0.
//   - Job buffer contents are not reset.
//  Job buffer: 128 x n regs, written on clock edge when ld_en_i&~busy_o.
//  FSM: IDLE -> SEND -> WAIT -> RECV -> DONE -> IDLE.
//  IDLE:
//   - start_i=1 -> SEND; tx index=0.
//   - rx bytes in IDLE are dropped.
//  SEND:
//   - tx_valid_o=1 from the first cycle after start; tx_data_o=buf[idx].
//   - On tx_valid_o&tx_ready_i: idx++. tx_data_o is held stable while ~tx_ready_i.
//   - Byte 0 first, byte 127 last, so miner word i = {b[4i+3],b[4i+2],b[4i+1],b[4i]}.
//   - After the byte-127 handshake: tx_valid_o=0 next cycle; rx index=0; timer=0; -> WAIT.
//   - rx bytes during SEND are dropped; the miner only answers after a full header.
//  WAIT/RECV:
//   - On rx_valid_i: hash_o[8*ridx +: 8] <= rx_data_i; ridx++; timer=0; WAIT->RECV.
//   - Bytes fill LSB first, matching the miner's right-shift output order.
//   - At the 32nd byte -> DONE; hash_o holds the full value at that edge.
//   - Otherwise timer++ each cycle. timer==TIMEOUT-1 without rx -> IDLE, timeout_o=1 for 1 cycle.
//   - Partially written hash_o bytes remain; done_o is not asserted.
//   - rx_valid_i and timer expiry in the same cycle: the byte wins, timer clears.
//  DONE: done_o=1 for exactly 1 cycle; -> IDLE. hash_o holds until the next job's first rx byte.
//  Back-to-back: start_i=1 in the cycle after DONE launches a new job; no bubble beyond the DONE cycle.
//  start_i or ld_en_i while busy_o=1: ignored, no effect on the current job.
//  Reset mid-operation: immediate return to IDLE, tx_valid_o=0 asynchronously, hash_o=0.
//  Counters: idx 7 bits wraps only via explicit clear; timer 24 bits saturating at TIMEOUT-1.
// TESTING
//  1 Load buf[i]=i, start, tx_ready_i=1 -> 128 consecutive tx bytes 0x00..0x7F, then tx_valid_o=0, busy_o=1.
//  2 Same job, tx_ready_i toggling 1-of-3 cycles -> tx_data_o stable while stalled; order 0x00..0x7F, none lost.
//  3 After send, rx bytes 0x01..0x20 spaced 10 cycles -> hash_o[7:0]=0x01, hash_o[255:248]=0x20;
//    done_o 1-cycle pulse after 32nd byte; busy_o=0 next cycle.
//  4 TIMEOUT=100, send 5 rx bytes then none -> timeout_o pulse 100 cycles after 5th byte; done_o=0;
//    FSM in IDLE; hash_o[39:0] holds the 5 received bytes.
//  5 rst_i=0 at byte 60 of SEND -> outputs 0 immediately; new start resends from byte 0x00.
//  6 start_i and ld_en_i(addr 0, 0xFF) during WAIT -> ignored; next job still sends original buf[0].

Source files
------------

// File: rtl/mining_host_if.sv
// Job-load, UART byte-stream and result signals of the mining host.
// The master side is the surrounding system (loader, UART TX/RX shims).
// The slave side is mining_host itself.
interface mining_host_if #(
  parameter int n         = 8,
  parameter int HDR_BYTES = 128,
  parameter int RES_BYTES = 32
);
  localparam int AW = $clog2(HDR_BYTES);

  logic                   ld_en;
  logic [AW-1:0]          ld_addr;
  logic [n-1:0]           ld_data;
  logic                   start;
  logic                   busy;
  logic [n-1:0]           tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [n-1:0]           rx_data;
  logic                   rx_valid;
  logic [n*RES_BYTES-1:0] hash;
  logic                   done;
  logic                   timeout;

  modport master (
    output ld_en, ld_addr, ld_data, start, tx_ready, rx_data, rx_valid,
    input  busy, tx_data, tx_valid, hash, done, timeout
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, tx_ready, rx_data, rx_valid,
    output busy, tx_data, tx_valid, hash, done, timeout
  );
endinterface

// File: rtl/mining_host.sv
// Host side of the UART mining core.
// Streams a stored block-header job out byte by byte.
// Then gathers the returned hash/nonce bytes into one wide word.
// A watchdog aborts the response phase if the miner goes quiet.
module mining_host #(
  parameter int n         = 8,
  parameter int HDR_BYTES = 128,
  parameter int RES_BYTES = 32,
  parameter int TIMEOUT   = 16777216
) (
  input logic        clk_i,
  input logic        rst_i,
  mining_host_if.slave bus
);
  localparam int AW = $clog2(HDR_BYTES);
  localparam int RW = $clog2(RES_BYTES);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [AW-1:0] LAST_TX   = AW'(HDR_BYTES - 1);
  localparam logic [RW-1:0] LAST_RX   = RW'(RES_BYTES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [n-1:0]           job_mem [HDR_BYTES];
  logic [AW-1:0]          tx_idx_reg;
  logic [RW-1:0]          rx_idx_reg;
  logic [TW-1:0]          timer_reg;
  logic                   timeout_reg;
  logic [n*RES_BYTES-1:0] hash_reg;

  logic listening;
  logic rx_fire;
  logic expire;

  assign listening = (state_reg == WAIT) || (state_reg == RECV);
  assign rx_fire   = listening && bus.rx_valid;
  // A byte arriving on the expiry cycle takes priority over the watchdog.
  assign expire    = listening && !bus.rx_valid && (timer_reg == TIMER_MAX);

  // Job buffer write port; loads only land while the host is idle so a running job is never disturbed.
  always_ff @(posedge clk_i) begin
    if (bus.ld_en && (state_reg == IDLE))
      job_mem[bus.ld_addr] <= bus.ld_data;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = SEND;
      SEND: if (bus.tx_ready && (tx_idx_reg == LAST_TX)) state_next = WAIT;
      WAIT, RECV: begin
        if (bus.rx_valid)
          state_next = (rx_idx_reg == LAST_RX) ? DONE : RECV;
        else if (timer_reg == TIMER_MAX)
          state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte indices, response watchdog and timeout pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_idx_reg  <= '0;
      rx_idx_reg  <= '0;
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= expire;
      case (state_reg)
        IDLE: tx_idx_reg <= '0;
        SEND: begin
          if (bus.tx_ready) begin
            if (tx_idx_reg == LAST_TX) begin
              tx_idx_reg <= '0;
              rx_idx_reg <= '0;
              timer_reg  <= '0;
            end else begin
              tx_idx_reg <= tx_idx_reg + AW'(1);
            end
          end
        end
        WAIT, RECV: begin
          if (bus.rx_valid) begin
            rx_idx_reg <= rx_idx_reg + RW'(1);
            timer_reg  <= '0;
          end else if (timer_reg != TIMER_MAX) begin
            timer_reg  <= timer_reg + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result assembly: byte k lands at [8k+7:8k], lowest byte first as the miner shifts it out.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       hash_reg <= '0;
    else if (rx_fire) hash_reg[rx_idx_reg*n +: n] <= bus.rx_data;
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.tx_valid = (state_reg == SEND);
  assign bus.tx_data  = (state_reg == SEND) ? job_mem[tx_idx_reg] : '0;
  assign bus.done     = (state_reg == DONE);
  assign bus.timeout  = timeout_reg;
  assign bus.hash     = hash_reg;
endmodule

// File: tb/tb_mining_host.sv
// Directed bench for mining_host: job send, stalled send, result collection, watchdog timeout,
// writes while busy, and reset in mid-send. The watchdog is shortened to 100 cycles.
module tb_mining_host;
  logic clk_i;
  logic rst_i;

  int checks;
  int errors;

  logic [255:0] exp_hash;

  mining_host_if #(.n(8), .HDR_BYTES(128), .RES_BYTES(32)) bus ();

  mining_host #(.n(8), .HDR_BYTES(128), .RES_BYTES(32), .TIMEOUT(100)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One rx strobe starting at the current negedge; returns on the negedge after it was taken.
  task automatic rx_byte(input logic [7:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    @(negedge clk_i);
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b tx_valid=%b done=%b timeout=%b, want all 0",
               bus.busy, bus.tx_valid, bus.done, bus.timeout);
    end
    checks++;
    if (bus.tx_data !== 8'h00 || bus.hash !== 256'h0) begin
      errors++;
      $display("FAIL reset_data: tx_data=%h hash=%h, want 0", bus.tx_data, bus.hash);
    end
    rst_i = 1'b1;
    $display("reset released");
  endtask

  task automatic load_job;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk_i);
      bus.ld_en   = 1'b1;
      bus.ld_addr = 7'(i);
      bus.ld_data = 8'(i);
    end
    @(negedge clk_i);
    bus.ld_en = 1'b0;
    $display("job loaded buf[i]=i");
  endtask

  task automatic test_send_full;
    @(negedge clk_i);
    bus.start    = 1'b1;
    bus.tx_ready = 1'b1;
    for (int b = 0; b < 128; b++) begin
      @(negedge clk_i);
      bus.start = 1'b0;
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(b)) begin
        errors++;
        $display("FAIL send_byte: slot %0d got valid=%b data=%h, want valid=1 data=%h",
                 b, bus.tx_valid, bus.tx_data, 8'(b));
      end
    end
    @(negedge clk_i);
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL send_end: tx_valid=%b busy=%b, want 0/1", bus.tx_valid, bus.busy);
    end
    $display("job sent 128 bytes, ready always high");
  endtask

  task automatic test_recv;
    exp_hash = '0;
    for (int k = 0; k < 32; k++) begin
      exp_hash[8*k +: 8] = 8'(k + 1);
      repeat (9) @(negedge clk_i);
      rx_byte(8'(k + 1));
      if (k < 31) begin
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL recv_partial: after byte %0d done=%b busy=%b, want 0/1", k + 1, bus.done, bus.busy);
        end
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL recv_done: done=%b busy=%b, want 1/1", bus.done, bus.busy);
    end
    checks++;
    if (bus.hash[7:0] !== 8'h01 || bus.hash[255:248] !== 8'h20) begin
      errors++;
      $display("FAIL recv_ends: low=%h high=%h, want 01/20", bus.hash[7:0], bus.hash[255:248]);
    end
    checks++;
    if (bus.hash !== exp_hash) begin
      errors++;
      $display("FAIL recv_hash: got %h want %h", bus.hash, exp_hash);
    end
    @(negedge clk_i);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL recv_after: done=%b busy=%b, want 0/0", bus.done, bus.busy);
    end
    $display("result received hash=%h", bus.hash);
  endtask

  // Launched on the idle cycle right after DONE, with the transmitter ready one cycle in three.
  task automatic test_back_to_back_stall;
    int exp_idx;
    int cyc;
    exp_idx      = 0;
    cyc          = 0;
    bus.start    = 1'b1;
    bus.tx_ready = 1'b0;
    while (exp_idx < 128 && cyc < 1000) begin
      @(negedge clk_i);
      bus.start = 1'b0;
      cyc++;
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(exp_idx)) begin
        errors++;
        $display("FAIL stall_byte: cycle %0d valid=%b data=%h, want valid=1 data=%h",
                 cyc, bus.tx_valid, bus.tx_data, 8'(exp_idx));
      end
      bus.tx_ready = (cyc % 3 == 0);
      if (bus.tx_ready) exp_idx++;
    end
    checks++;
    if (exp_idx != 128) begin
      errors++;
      $display("FAIL stall_budget: sent %0d bytes, want 128", exp_idx);
    end
    @(negedge clk_i);
    bus.tx_ready = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_end: tx_valid=%b busy=%b, want 0/1", bus.tx_valid, bus.busy);
    end
    $display("job sent 128 bytes with stalls in %0d cycles", cyc);
  endtask

  task automatic test_ignore_busy;
    bus.start   = 1'b1;
    bus.ld_en   = 1'b1;
    bus.ld_addr = 7'd0;
    bus.ld_data = 8'hFF;
    @(negedge clk_i);
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: busy=%b tx_valid=%b, want 1/0", bus.busy, bus.tx_valid);
    end
    $display("start and load pulsed while waiting");
  endtask

  task automatic test_timeout;
    int  waited;
    bit  seen;
    bit  saw_done;
    seen     = 1'b0;
    saw_done = 1'b0;
    waited   = 0;
    for (int k = 0; k < 5; k++) begin
      repeat (2) @(negedge clk_i);
      rx_byte(8'hA1 + 8'(k));
    end
    for (int k = 1; k <= 150 && !seen; k++) begin
      @(negedge clk_i);
      if (bus.done === 1'b1) saw_done = 1'b1;
      if (bus.timeout === 1'b1) begin
        seen   = 1'b1;
        waited = k;
      end
    end
    checks++;
    if (!seen || waited != 100) begin
      errors++;
      $display("FAIL timeout_delay: seen=%0d after %0d cycles, want pulse after 100", seen, waited);
    end
    checks++;
    if (saw_done || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: saw_done=%0d busy=%b, want 0/0", saw_done, bus.busy);
    end
    checks++;
    if (bus.hash[39:0] !== 40'hA5A4A3A2A1 || bus.hash[255:40] !== exp_hash[255:40]) begin
      errors++;
      $display("FAIL timeout_hash: got %h want low A5A4A3A2A1 over %h", bus.hash, exp_hash[255:40]);
    end
    @(negedge clk_i);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: timeout=%b one cycle later, want 0", bus.timeout);
    end
    $display("response timed out after %0d idle cycles", waited);
  endtask

  task automatic test_reset_mid;
    bus.start    = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (61) begin
      @(negedge clk_i);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.tx_data !== 8'd60 || bus.tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pos: tx_data=%h valid=%b, want 3c/1", bus.tx_data, bus.tx_valid);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.tx_data !== 8'h00 ||
        bus.hash !== 256'h0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b data=%h done=%b timeout=%b hash=%h, want all 0",
               bus.tx_valid, bus.busy, bus.tx_data, bus.done, bus.timeout, bus.hash);
    end
    @(negedge clk_i);
    rst_i     = 1'b1;
    bus.start = 1'b1;
    @(negedge clk_i);
    bus.start = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL restart_first: valid=%b data=%h, want 1/00 (original buf[0])", bus.tx_valid, bus.tx_data);
    end
    @(negedge clk_i);
    checks++;
    if (bus.tx_data !== 8'h01) begin
      errors++;
      $display("FAIL restart_second: data=%h, want 01", bus.tx_data);
    end
    rst_i = 1'b0;
    $display("reset during send, job restarted from byte 0");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    exp_hash     = '0;
    rst_i        = 1'b0;
    bus.ld_en    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.start    = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;

    test_reset;
    load_job;
    test_send_full;
    test_recv;
    test_back_to_back_stall;
    test_ignore_busy;
    test_timeout;
    test_reset_mid;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
